// File: rtl/gcm_pkg.sv
// Shared widths, limits and the sequencer state type for the GCM GCTR sequencer.
package gcm_pkg;

  localparam int GCM_BLK_W   = 128;
  localparam int GCM_KEY_W   = 256;
  localparam int GCM_IV_W    = 96;
  localparam int GCM_CNT_W   = 16;
  localparam int GCM_TIMEOUT = 255;
  localparam int GCM_WD_W    = 8;

  // Watchdog fires on the edge where the count would reach GCM_TIMEOUT.
  localparam logic [GCM_WD_W-1:0] GCM_WD_LAST = GCM_WD_W'(GCM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HKEY,
    ST_Y0,
    ST_DWAIT,
    ST_DRUN,
    ST_OHOLD,
    ST_FIN
  } gcm_state_e;

endpackage

// File: rtl/gcm_gctr_seq.sv
// Sequences one GCM message through an external GCTR engine: H, E(K,Y0), then N data blocks.
// Optional watchdog on outstanding GCTR ops when GCM_GCTR_SEQ_TIMEOUT_EN is defined.
module gcm_gctr_seq
  import gcm_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic                 iStart,
  input  logic [GCM_KEY_W-1:0] iKey,
  input  logic                 iKeylen,
  input  logic [GCM_IV_W-1:0]  iIV,
  input  logic [GCM_CNT_W-1:0] iNumBlocks,
  input  logic [GCM_BLK_W-1:0] iData,
  input  logic                 iData_valid,
  output logic                 oData_ready,
  output logic [GCM_BLK_W-1:0] oOut,
  output logic                 oOut_valid,
  input  logic                 iOut_ready,
  output logic [GCM_BLK_W-1:0] oH,
  output logic                 oH_valid,
  output logic [GCM_BLK_W-1:0] oEKY0,
  output logic                 oEKY0_valid,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oError,
  output logic                 oG_Init,
  output logic                 oG_HashKey,
  output logic                 oG_Y0,
  output logic [GCM_KEY_W-1:0] oG_Key,
  output logic                 oG_Key_valid,
  output logic                 oG_Keylen,
  output logic [GCM_IV_W-1:0]  oG_IV,
  output logic                 oG_IV_valid,
  output logic [GCM_BLK_W-1:0] oG_Block,
  output logic                 oG_Block_valid,
  input  logic [GCM_BLK_W-1:0] iG_Result,
  input  logic                 iG_Result_valid
);

  gcm_state_e           state_q;
  logic [GCM_CNT_W-1:0] cnt_q;
  logic                 res_valid_q;
  logic                 op_done;

  // Only a fresh 0->1 of the result strobe while an op is outstanding completes it.
  assign op_done = oG_Init & iG_Result_valid & ~res_valid_q;

  assign oG_Key_valid = oG_Init;
  assign oG_IV_valid  = oG_Init;

`ifdef GCM_GCTR_SEQ_TIMEOUT_EN
  logic [GCM_WD_W-1:0] wd_q;
`else
  assign oError = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      // NOTE: data registers are reset as well, so an aborted message leaves nothing stale on the outputs.
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      res_valid_q    <= 1'b0;
      oG_Key         <= '0;
      oG_Keylen      <= 1'b0;
      oG_IV          <= '0;
      oG_Block       <= '0;
      oG_Init        <= 1'b0;
      oG_HashKey     <= 1'b0;
      oG_Y0          <= 1'b0;
      oG_Block_valid <= 1'b0;
      oData_ready    <= 1'b0;
      oOut           <= '0;
      oOut_valid     <= 1'b0;
      oH             <= '0;
      oH_valid       <= 1'b0;
      oEKY0          <= '0;
      oEKY0_valid    <= 1'b0;
      oBusy          <= 1'b0;
      oDone          <= 1'b0;
`ifdef GCM_GCTR_SEQ_TIMEOUT_EN
      wd_q           <= '0;
      oError         <= 1'b0;
`endif
    end else begin
      // NOTE: every flop uses <=, so all branches below see pre-edge values regardless of order.
      res_valid_q <= iG_Result_valid;
      oDone       <= 1'b0;
`ifdef GCM_GCTR_SEQ_TIMEOUT_EN
      oError      <= 1'b0;
      // oG_Init is low for at least a cycle before every issue, which clears the count.
      wd_q        <= oG_Init ? wd_q + 1'b1 : '0;
`endif

      unique case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            oG_Key      <= iKey;
            oG_Keylen   <= iKeylen;
            oG_IV       <= iIV;
            cnt_q       <= iNumBlocks;
            oH_valid    <= 1'b0;
            oEKY0_valid <= 1'b0;
            oBusy       <= 1'b1;
            oG_HashKey  <= 1'b1;
            oG_Init     <= 1'b1;
            state_q     <= ST_HKEY;
          end
        end

        ST_HKEY: begin
          if (op_done) begin
            oH         <= iG_Result;
            oH_valid   <= 1'b1;
            oG_Init    <= 1'b0;
            oG_HashKey <= 1'b0;
            oG_Y0      <= 1'b1;
            state_q    <= ST_Y0;
          end
        end

        ST_Y0: begin
          // Entered with oG_Init low, giving the engine its mandatory idle gap.
          if (!oG_Init) begin
            oG_Init <= 1'b1;
          end else if (op_done) begin
            oEKY0       <= iG_Result;
            oEKY0_valid <= 1'b1;
            oG_Init     <= 1'b0;
            oG_Y0       <= 1'b0;
            if (cnt_q != '0) begin
              oData_ready <= 1'b1;
              state_q     <= ST_DWAIT;
            end else begin
              oDone   <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end

        ST_DWAIT: begin
          if (iData_valid && oData_ready) begin
            oG_Block       <= iData;
            oData_ready    <= 1'b0;
            oG_Block_valid <= 1'b1;
            oG_Init        <= 1'b1;
            state_q        <= ST_DRUN;
          end
        end

        ST_DRUN: begin
          if (op_done) begin
            oOut           <= iG_Result;
            oOut_valid     <= 1'b1;
            cnt_q          <= cnt_q - 1'b1;
            oG_Init        <= 1'b0;
            oG_Block_valid <= 1'b0;
            state_q        <= ST_OHOLD;
          end
        end

        ST_OHOLD: begin
          if (iOut_ready) begin
            oOut_valid <= 1'b0;
            if (cnt_q != '0) begin
              oData_ready <= 1'b1;
              state_q     <= ST_DWAIT;
            end else begin
              oDone   <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end

        ST_FIN: begin
          oBusy   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

`ifdef GCM_GCTR_SEQ_TIMEOUT_EN
      // Placed after the case so an expiring op overrides whatever the state decided.
      if (oG_Init && !op_done && wd_q == GCM_WD_LAST) begin
        oError         <= 1'b1;
        oG_Init        <= 1'b0;
        oG_HashKey     <= 1'b0;
        oG_Y0          <= 1'b0;
        oG_Block_valid <= 1'b0;
        oData_ready    <= 1'b0;
        oOut_valid     <= 1'b0;
        oBusy          <= 1'b0;
        state_q        <= ST_IDLE;
      end
`endif
    end
  end

endmodule

// File: doc/gcm_gctr_seq.md
GCM_GCTR_SEQ -- requirements
Module: gcm_gctr_seq

Interface
REQ-001 Parameter: none; all widths come from the shared package.
REQ-002 iClk  in  1  single clock; every flop is rising-edge.
REQ-003 iRstn  in  1  reset, asynchronous and active-low.
REQ-004 iStart, iKey, iKeylen, iIV, iNumBlocks  in  1/256/1/96/16  message launch pulse plus its key, key length, IV and data block count.
REQ-005 iData, iData_valid / oData_ready  in/out  128,1/1  upstream plaintext-or-ciphertext block handshake.
REQ-006 oOut, oOut_valid / iOut_ready  out/in  128,1/1  downstream GCTR result handshake.
REQ-007 oH, oH_valid, oEKY0, oEKY0_valid  out  128,1,128,1  hash key and E(K,Y0), each held until the next iStart.
REQ-008 oBusy, oDone, oError  out  1  busy level, one-cycle done pulse, one-cycle error pulse.
REQ-009 GCTR-side initiator ports: oG_Init, oG_HashKey, oG_Y0, oG_Key(256), oG_Key_valid, oG_Keylen, oG_IV(96), oG_IV_valid, oG_Block(128), oG_Block_valid as outputs; iG_Result(128), iG_Result_valid as inputs.

Function
REQ-010 States: IDLE, HKEY, Y0, DWAIT, DRUN, OHOLD, FIN.
REQ-011 IDLE: iStart captures iKey, iKeylen, iIV and iNumBlocks, clears oH_valid and oEKY0_valid, and moves to HKEY. iStart is ignored in every other state.
REQ-012 Op issue, in HKEY, Y0 and DRUN:
- oG_Init, oG_Key_valid and oG_IV_valid are held at 1 from state entry until the op completes.
- oG_HashKey=1 in HKEY only; oG_Y0=1 in Y0 only.
- oG_Block_valid=1 in DRUN only.
REQ-013 Op completion is a rising edge of iG_Result_valid (registered previous value 0, current value 1). A level that stays high from an earlier op never completes an op.
REQ-014 On completion, oG_Init drops to 0 for at least one cycle before the next op is issued.
REQ-015 HKEY completion: iG_Result loads into oH, oH_valid=1, next state Y0.
REQ-016 Y0 completion: iG_Result loads into oEKY0, oEKY0_valid=1. Next state is DWAIT if the block count is nonzero, else FIN.
REQ-017 DWAIT: oData_ready=1. An iData_valid&oData_ready cycle latches iData onto oG_Block, next state DRUN.
REQ-018 DRUN completion: iG_Result loads into the output register, oOut_valid=1, remaining count decrements, next state OHOLD.
REQ-019 OHOLD: oOut is held stable until iOut_ready. Then oOut_valid=0, and the next state is DWAIT if the count is nonzero, else FIN.
REQ-020 FIN: oDone=1 for one cycle, then IDLE. oBusy=1 in every state except IDLE.
REQ-021 Block count is 16-bit unsigned. 0 means H and Y0 only; 65535 is legal; no wrap.
REQ-022 oData_ready is 0 outside DWAIT. oOut_valid is 0 outside OHOLD.

Reset
REQ-023 iRstn low sets, within the same cycle and without a clock:
- state IDLE; all valid, ready, oG_* strobe, oBusy, oDone and oError outputs to 0;
- all data registers, oH and oEKY0 to 0.
REQ-024 Reset mid-operation abandons the message with no oDone. The GCTR block must be reset alongside.

Configuration
REQ-025 Macro GCM_GCTR_SEQ_TIMEOUT_EN, when defined, adds an 8-bit watchdog:
- cleared on each op issue; counts while an op is outstanding;
- at 255 cycles: oError=1 for one cycle, all oG_* strobes drop, state returns to IDLE, no oDone.
REQ-026 Without the macro there is no watchdog logic and oError is tied to 0.

Structure
REQ-027 Package gcm_pkg holds the state enum, GCM_BLK_W=128, GCM_KEY_W=256, GCM_IV_W=96, GCM_CNT_W=16 and GCM_TIMEOUT=255.
REQ-028 Single module with no sub-module; the edge detect and watchdog are inline.

Verification
REQ-029 Key=0, IV=0, NumBlocks=0 -> oH=66e94bd4ef8a2c3b884cfa59ca342b2e, oEKY0=58e2fccefa7e3061367f1d57a4e7455a, then one oDone pulse, and oData_ready never asserts.
REQ-030 Same key and IV, NumBlocks=1, data=0 -> oOut=0388dace60b6a392f328c2b971b2fe78, then oDone.
REQ-031 NumBlocks=3 with iOut_ready held low 10 cycles per block -> oOut stays stable throughout, exactly 3 transfers, oData_ready only in DWAIT.
REQ-032 iG_Result_valid held high across two ops -> second op completes only on a new rising edge, and oG_Init shows a low gap of at least one cycle.
REQ-033 iRstn pulsed low during DRUN -> all outputs 0 immediately, state IDLE, no oDone.
REQ-034 With GCM_GCTR_SEQ_TIMEOUT_EN, iG_Result_valid stuck at 0 -> oError pulse 255 cycles after issue, then IDLE; a new iStart is accepted.
